// File: rtl/ecc_err_logger_pkg.sv
// Shared constants and log-entry type for the ECC error logger.
// ECC_ERR_LOG_DATA_EN adds the read data to each log entry.
package ecc_err_logger_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int RD_LATENCY = 1;

`ifdef ECC_ERR_LOG_DATA_EN
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } log_entry_t;
`else
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
  } log_entry_t;
`endif

endpackage

// File: rtl/ecc_err_logger_if.sv
// Log drain handshake between the error logger (slave) and the CSR/debug consumer (master).
// ECC_ERR_LOG_DATA_EN adds the log_data field.
interface ecc_err_logger_if;
  import ecc_err_logger_pkg::*;

  logic                  log_valid;
  logic [ADDR_WIDTH-1:0] log_addr;
  logic                  log_ready;
`ifdef ECC_ERR_LOG_DATA_EN
  logic [DATA_WIDTH-1:0] log_data;

  modport slave  (output log_valid, output log_addr, output log_data, input  log_ready);
  modport master (input  log_valid, input  log_addr, input  log_data, output log_ready);
`else
  modport slave  (output log_valid, output log_addr, input  log_ready);
  modport master (input  log_valid, input  log_addr, output log_ready);
`endif

endinterface

// File: rtl/ecc_log_fifo.sv
// Synchronous FIFO for logged error entries; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module ecc_log_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_INC = {{PW{1'b0}}, 1'b1};

  logic [PW:0]      wr_ptr_r;
  logic [PW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             pop_s;
  logic             push_s;

  // Full/empty from the extra pointer MSB; gate push and pop with them.
  always_comb begin
    o_empty = (wr_ptr_r == rd_ptr_r);
    o_full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    pop_s   = i_pop && !o_empty;
    push_s  = i_push && (!o_full || pop_s);
  end

  assign o_rdata = mem_r[rd_ptr_r[PW-1:0]];

  // Storage and pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[PW-1:0]] <= i_wdata;
        wr_ptr_r                <= wr_ptr_r + PTR_INC;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end
    end
  end

endmodule

// File: rtl/ecc_err_logger.sv
// Snoops one RAM port, matches read responses to their addresses and logs double-bit errors.
// ECC_ERR_LOG_DATA_EN also logs the failing read data on log_if.log_data.
module ecc_err_logger
  import ecc_err_logger_pkg::*;
#(
  parameter int RD_LATENCY = ecc_err_logger_pkg::RD_LATENCY,
  parameter int LOG_DEPTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_dout,
  input  logic                  i_error,
  input  logic                  i_clr,
  ecc_err_logger_if.slave       log_if,
  output logic [CNT_WIDTH-1:0]  o_err_cnt,
  output logic                  o_overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [RD_LATENCY-1:0] pipe_vld_r;
  logic [ADDR_WIDTH-1:0] pipe_addr_r [RD_LATENCY];
  logic [CNT_WIDTH-1:0]  err_cnt_r;
  logic                  overflow_r;

  logic       evt_s;
  logic       pop_s;
  logic       drop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  log_entry_t wr_entry_s;
  log_entry_t rd_entry_s;

  // Read tracking: stage RD_LATENCY-1 lines up with the response sampled this edge.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_addr_r[i] <= '0;
      end
    end else begin
      pipe_vld_r[0]  <= i_en & ~i_we;
      pipe_addr_r[0] <= i_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_addr_r[i] <= pipe_addr_r[i-1];
      end
    end
  end

  // Error event, pop and the full-without-pop drop condition.
  always_comb begin
    evt_s           = pipe_vld_r[RD_LATENCY-1] & i_error;
    pop_s           = ~fifo_empty_s & log_if.log_ready;
    drop_s          = evt_s & fifo_full_s & ~pop_s;
    wr_entry_s      = '0;
    wr_entry_s.addr = pipe_addr_r[RD_LATENCY-1];
`ifdef ECC_ERR_LOG_DATA_EN
    wr_entry_s.data = i_dout;
`endif
  end

`ifndef ECC_ERR_LOG_DATA_EN
  logic dout_unused_s;
  assign dout_unused_s = ^i_dout;
`endif

  ecc_log_fifo #(
    .WIDTH ($bits(log_entry_t)),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_push  (evt_s),
    .i_wdata (wr_entry_s),
    .i_pop   (pop_s),
    .o_rdata (rd_entry_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s)
  );

  // Saturating event counter; a clear coinciding with an event restarts at one.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      err_cnt_r <= '0;
    end else if (i_clr) begin
      err_cnt_r <= evt_s ? CNT_ONE : '0;
    end else if (evt_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_ONE;
    end
  end

  // Sticky overflow; a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= drop_s | (overflow_r & ~i_clr);
    end
  end

  assign o_err_cnt        = err_cnt_r;
  assign o_overflow       = overflow_r;
  assign log_if.log_valid = ~fifo_empty_s;
  assign log_if.log_addr  = rd_entry_s.addr;
`ifdef ECC_ERR_LOG_DATA_EN
  assign log_if.log_data  = rd_entry_s.data;
`endif

endmodule

// File: tb/tb_ecc_err_logger.sv
// Three logger instances (latency 1, 4-bit counter, latency 3) share one stimulus stream
// and are each compared every cycle against a queue-based reference model.
module tb_ecc_err_logger;
  import ecc_err_logger_pkg::*;

  localparam int NI    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, en, we, error, clr, ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] dout;
  logic [15:0]           cnt0, cnt2;
  logic [3:0]            cnt1;
  logic                  ovf0, ovf1, ovf2;

  ecc_err_logger_if if0 ();
  ecc_err_logger_if if1 ();
  ecc_err_logger_if if2 ();
  assign if0.log_ready = ready;
  assign if1.log_ready = ready;
  assign if2.log_ready = ready;

  ecc_err_logger #(.RD_LATENCY(1), .LOG_DEPTH(DEPTH), .CNT_WIDTH(16)) u0 (
    .clk(clk), .i_rst_n(rst_n), .i_en(en), .i_we(we), .i_addr(addr), .i_dout(dout),
    .i_error(error), .i_clr(clr), .log_if(if0), .o_err_cnt(cnt0), .o_overflow(ovf0));
  ecc_err_logger #(.RD_LATENCY(1), .LOG_DEPTH(DEPTH), .CNT_WIDTH(4)) u1 (
    .clk(clk), .i_rst_n(rst_n), .i_en(en), .i_we(we), .i_addr(addr), .i_dout(dout),
    .i_error(error), .i_clr(clr), .log_if(if1), .o_err_cnt(cnt1), .o_overflow(ovf1));
  ecc_err_logger #(.RD_LATENCY(3), .LOG_DEPTH(DEPTH), .CNT_WIDTH(16)) u2 (
    .clk(clk), .i_rst_n(rst_n), .i_en(en), .i_we(we), .i_addr(addr), .i_dout(dout),
    .i_error(error), .i_clr(clr), .log_if(if2), .o_err_cnt(cnt2), .o_overflow(ovf2));

  // Reference model: history of issued reads, one queue per logger, plain counters.
  int                    lat  [NI] = '{1, 1, 3};
  int                    cmax [NI] = '{65535, 15, 65535};
  int                    cyc, last_rst, total, bad;
  bit                    hv [8192];
  logic [ADDR_WIDTH-1:0] ha [8192];
  logic [ADDR_WIDTH-1:0] mq_a [NI][$];
  logic [DATA_WIDTH-1:0] mq_d [NI][$];
  int                    mcnt [NI];
  bit                    movf [NI];
  bit                    fresh [NI];
  logic [31:0]           last_pop;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    cyc++;
    hv[cyc] = en && !we;
    ha[cyc] = addr;
    if (!rst_n) begin
      last_rst = cyc;
      for (int k = 0; k < NI; k++) begin
        mq_a[k].delete(); mq_d[k].delete();
        mcnt[k] = 0; movf[k] = 1'b0; fresh[k] = 1'b1;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        int src;
        bit evt, pop, drop;
        src  = cyc - lat[k];
        evt  = (src > last_rst) && hv[src] && error;
        pop  = (mq_a[k].size() > 0) && ready;
        drop = evt && (mq_a[k].size() == DEPTH) && !pop;
        if (pop) begin
          void'(mq_a[k].pop_front());
          void'(mq_d[k].pop_front());
        end
        if (evt && !drop) begin
          mq_a[k].push_back(ha[src]);
          mq_d[k].push_back(dout);
          fresh[k] = 1'b0;
        end
        if (clr) mcnt[k] = evt ? 1 : 0;
        else if (evt && mcnt[k] < cmax[k]) mcnt[k]++;
        movf[k] = drop || (movf[k] && !clr);
      end
    end
  endtask

  task automatic chk_inst(int k, logic v, logic [ADDR_WIDTH-1:0] a, logic [31:0] c, logic o);
    chk($sformatf("u%0d.valid", k), 32'(v), 32'(mq_a[k].size() > 0));
    if (mq_a[k].size() > 0) chk($sformatf("u%0d.addr", k), 32'(a), 32'(mq_a[k][0]));
    else if (fresh[k]) chk($sformatf("u%0d.addr_rst", k), 32'(a), 32'd0);
    chk($sformatf("u%0d.cnt", k), c, 32'(mcnt[k]));
    chk($sformatf("u%0d.ovf", k), 32'(o), 32'(movf[k]));
  endtask

  task automatic check_all();
    chk_inst(0, if0.log_valid, if0.log_addr, 32'(cnt0), ovf0);
    chk_inst(1, if1.log_valid, if1.log_addr, 32'(cnt1), ovf1);
    chk_inst(2, if2.log_valid, if2.log_addr, 32'(cnt2), ovf2);
`ifdef ECC_ERR_LOG_DATA_EN
    if (mq_d[0].size() > 0) chk("u0.data", if0.log_data, mq_d[0][0]);
    if (mq_d[1].size() > 0) chk("u1.data", if1.log_data, mq_d[1][0]);
    if (mq_d[2].size() > 0) chk("u2.data", if2.log_data, mq_d[2][0]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(bit e, bit w, logic [ADDR_WIDTH-1:0] a, bit err, bit c, bit r);
    en = e; we = w; addr = a; error = err; clr = c; ready = r;
    dout = $urandom;
  endtask

  task automatic drain();
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; last_rst = 0;
    for (int k = 0; k < NI; k++) begin
      mcnt[k] = 0; movf[k] = 1'b0; fresh[k] = 1'b1;
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_valid", 32'(if0.log_valid), 32'd0);
    chk("rst_addr", 32'(if0.log_addr), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    rst_n = 1'b1;

    // Single erroring read at 0x05.
    drive(1'b1, 1'b0, 10'h005, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0); tick();
    chk("tp1_valid", 32'(if0.log_valid), 32'd1);
    chk("tp1_addr", 32'(if0.log_addr), 32'h005);
    chk("tp1_cnt", 32'(cnt0), 32'd1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1); tick();

    // Write followed by a stray error flag: nothing logged.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 10'h007, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
    chk("tp2_cnt", 32'(cnt0), 32'd0);
    chk("tp2_valid", 32'(if0.log_valid), 32'd0);

    // Nine erroring reads into an eight-entry FIFO.
    for (int i = 0; i < 10; i++) begin
      drive(i < 9, 1'b0, 10'(32'h10 + i), i >= 1, 1'b0, 1'b0); tick();
    end
    chk("tp3_ovf", 32'(ovf0), 32'd1);
    chk("tp3_cnt", 32'(cnt0), 32'd9);
    for (int j = 0; j < 8; j++) begin
      chk("tp3_pop", 32'(if0.log_addr), 32'h10 + 32'(j));
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
    end
    chk("tp3_empty", 32'(if0.log_valid), 32'd0);

    // Full FIFO with a pop on the same edge as the error on 0x20.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(i < 9, 1'b0, (i < 8) ? 10'(32'h30 + i) : 10'h020, i >= 1, 1'b0, i == 9); tick();
    end
    chk("tp4_ovf", 32'(ovf0), 32'd0);
    last_pop = 32'd0;
    for (int j = 0; j < 8; j++) begin
      last_pop = 32'(if0.log_addr);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
    end
    chk("tp4_last", last_pop, 32'h020);

    // Counter saturation on the 4-bit instance, then clear with an event.
    drain();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 18; i++) begin
      drive(i < 17, 1'b0, 10'(32'h40 + i), i >= 1, 1'b0, 1'b0); tick();
    end
    chk("tp5_sat", 32'(cnt1), 32'd15);
    chk("tp5_ovf", 32'(ovf1), 32'd1);
    drain();
    drive(1'b1, 1'b0, 10'h055, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0); tick();
    chk("tp5_clr_cnt", 32'(cnt1), 32'd1);
    chk("tp5_clr_ovf", 32'(ovf1), 32'd0);

    // Latency-3 instance: back-to-back reads, only 0x2 errors.
    drain();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 1'b0, 10'(i + 1), i == 4, 1'b0, 1'b0); tick();
    end
    chk("tp6_valid", 32'(if2.log_valid), 32'd1);
    chk("tp6_addr", 32'(if2.log_addr), 32'h002);
    chk("tp6_cnt", 32'(cnt2), 32'd1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
    chk("tp6_single", 32'(if2.log_valid), 32'd0);

    // Same reads with a reset landing while they are in flight.
    for (int i = 0; i < 6; i++) begin
      rst_n = (i != 3);
      drive(i < 3, 1'b0, 10'(i + 1), i >= 3, 1'b0, 1'b0); tick();
    end
    rst_n = 1'b1;
    chk("tp6_rst_valid", 32'(if2.log_valid), 32'd0);
    chk("tp6_rst_cnt", 32'(cnt2), 32'd0);
    chk("tp6_rst_ovf", 32'(ovf2), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 10'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_err_logger.md
Name: ecc_err_logger

Overview:
- Sits downstream of one port of the Hamming-protected dual-port RAM. It snoops that port's request signals (en, we, addr) and its response signals (dout, error).
- It matches each read response to its issuing address, counts double-bit error events, and queues the failing addresses in a small FIFO.
- A CSR/debug master drains the FIFO through a valid/ready handshake.
- One instance is placed per RAM port.

Parameters:
- DATA_WIDTH, 32, RAM data width; taken from the shared package.
- ADDR_WIDTH, 10, RAM address width; taken from the shared package.
- RD_LATENCY, 1, cycles from read request to valid o_dout/o_error; legal range 1..4.
- LOG_DEPTH, 8, error FIFO depth; must be a power of 2, at least 2.
- CNT_WIDTH, 16, error event counter width.

Ports:
- clk  input  1  port clock; the same clock as the snooped RAM port.
- i_rst_n  input  1  synchronous active-low reset.
- i_en  input  1  snooped RAM port enable.
- i_we  input  1  snooped RAM write enable.
- i_addr  input  ADDR_WIDTH  snooped RAM address.
- i_dout  input  DATA_WIDTH  RAM read data (o_dout of the RAM).
- i_error  input  1  RAM double-bit error flag (o_error of the RAM).
- i_clr  input  1  clears the error counter and the overflow flag.
- o_log_valid  output  1  FIFO is non-empty.
- o_log_addr  output  ADDR_WIDTH  address at the FIFO head.
- i_log_ready  input  1  pop request from the consumer.
- o_err_cnt  output  CNT_WIDTH  saturating count of error events.
- o_overflow  output  1  sticky flag: an error was dropped because the FIFO was full.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: every flop updates only on the rising edge of clk, and i_rst_n=0 is sampled at that edge.
- Reset values:
  - o_log_valid=0, o_log_addr=0, o_err_cnt=0, o_overflow=0.
  - FIFO pointers and occupancy are 0.
  - All tracking-pipeline valid bits are 0.
- Read tracking:
  - A read is issued at edge t when i_en=1 and i_we=0.
  - A RD_LATENCY-deep shift register carries {valid, addr}.
  - The stage-RD_LATENCY entry is aligned with the i_dout/i_error values sampled at edge t+RD_LATENCY.
  - Writes and idle cycles shift in valid=0.
  - Back-to-back reads are fully pipelined.
- Error event: aligned valid=1 and i_error=1. i_error without an aligned valid is ignored.
- Counter:
  - Increments by 1 per error event.
  - Saturates at all-ones and never wraps.
  - If i_clr and an error event occur in the same cycle, the counter becomes 1.
  - If i_clr is asserted alone, the counter becomes 0.
- FIFO push: on an error event, the aligned addr is written if the FIFO is not full.
- FIFO full:
  - If the FIFO is full and there is no pop, the entry is dropped and o_overflow is set to 1.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted, occupancy is unchanged, and there is no overflow.
- o_overflow:
  - Cleared only by i_clr or reset.
  - If i_clr and an overflowing drop occur in the same cycle, o_overflow ends at 1.
- Pop: occurs when o_log_valid and i_log_ready are both 1 at an edge; the head advances.
  - i_log_ready is ignored while the FIFO is empty.
- There is no bypass: a pushed entry appears on o_log_valid/o_log_addr one cycle after the push edge.
- Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
- Pointers are (log2(LOG_DEPTH)+1) bits and wrap naturally. full/empty are derived from the MSB compare.
- o_log_addr is driven from registered FIFO storage at the read pointer.
- i_clr does not touch the FIFO contents.
- Reset mid-operation: reads in flight are discarded, the FIFO is emptied, and outputs return to their reset values on the next edge.

Optional Feature:
- Macro: ECC_ERR_LOG_DATA_EN.
- Defined:
  - Each FIFO entry also stores the aligned i_dout, presented on an extra output o_log_data [DATA_WIDTH].
  - o_log_data is reset to 0 and follows the same handshake as o_log_addr.
- Undefined: the port and its storage are absent, and the block behaves as described above.

Decomposition:
- Shared package holds:
  - DATA_WIDTH, ADDR_WIDTH, RD_LATENCY.
  - A typedef for a log entry: a packed struct {addr, data}, with the data field used only under ECC_ERR_LOG_DATA_EN.
- One sub-module, ecc_log_fifo:
  - Synchronous FIFO parameterised on width and depth.
  - Push and pop with the full-with-pop rule above.
  - Outputs full/empty.
- The top level holds the tracking pipeline, the counter and the overflow logic.

Test Plan:
- Reset, then read addr 0x05 with i_error=1 at t+1 (RD_LATENCY=1) -> o_log_valid=1 at t+2 with o_log_addr=0x05, o_err_cnt=1.
- Write to 0x07 with i_error forced to 1 one cycle later -> no log entry and o_err_cnt stays 0.
- Nine consecutive erroring reads (0x10..0x18) with i_log_ready=0 -> FIFO holds 0x10..0x17, o_overflow=1, o_err_cnt=9. Then pop 8 times -> addresses are returned in order and o_log_valid=0.
- FIFO full with i_log_ready=1 in the same cycle as an error on 0x20 -> no overflow, and 0x20 is the last entry popped.
- CNT_WIDTH=4 with 17 error events -> o_err_cnt=15. Then i_clr together with an error -> o_err_cnt=1, o_overflow=0.
- RD_LATENCY=3 with back-to-back reads 0x1,0x2,0x3 where only 0x2 errors; assert i_rst_n=0 mid-stream in a second run -> first run logs only 0x2; second run clears all state and logs nothing from the discarded in-flight reads.
